cpu_ctrl_fsm: RTL

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_fsm
// Brief    : Multi-cycle CPU control FSM (fetch/decode/exec/mem/writeback).
//            Optional mem_ack watchdog enabled by macro CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       inst_add,
    input  logic       inst_sub,
    input  logic       inst_or,
    input  logic       inst_and,
    input  logic       inst_beq,
    input  logic       inst_lw,
    input  logic       inst_sw,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_branch,
    output logic       reg_we,
    output logic       wb_mem,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_alu_op;
    logic       r_is_lw;
    logic       r_is_sw;
    logic       r_illegal;
    logic [1:0] w_exec_op;
    logic       w_flag_ok;
    logic       w_set_illegal;
    logic       w_wait_expired;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_unused
    end

    assign w_flag_ok = $onehot({inst_add, inst_sub, inst_or, inst_and,
                                inst_beq, inst_lw, inst_sw});

    always_comb begin
        w_exec_op = 2'b00;
        if (inst_sub || inst_beq) w_exec_op = 2'b01;
        else if (inst_or)         w_exec_op = 2'b10;
        else if (inst_and)        w_exec_op = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Operation and memory kind are captured on EXEC exit so alu_op and the
    // MEM/WB selects stay stable even if the decoder flags move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op  <= 2'b00;
            r_is_lw   <= 1'b0;
            r_is_sw   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_alu_op <= w_exec_op;
                r_is_lw  <= inst_lw;
                r_is_sw  <= inst_sw;
            end
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_branch     = 1'b0;
        reg_we        = 1'b0;
        wb_mem        = 1'b0;
        alu_op        = 2'b00;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DEC;
                end else if (w_wait_expired) begin
                    w_next = S_HALT;
                end
            end
            S_DEC: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (!w_flag_ok) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    alu_op = w_exec_op;
                    if (inst_lw || inst_sw) begin
                        w_next = S_MEM;
                    end else if (inst_beq) begin
                        pc_we     = alu_zero;
                        pc_branch = alu_zero;
                        w_next    = run ? S_FETCH : S_IDLE;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = r_is_sw;
                alu_op   = r_alu_op;
                if (mem_ack) begin
                    if (r_is_lw) w_next = S_WB;
                    else         w_next = run ? S_FETCH : S_IDLE;
                end else if (w_wait_expired) begin
                    w_next = S_HALT;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_mem = r_is_lw;
                alu_op = r_alu_op;
                w_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_CNT_W-1:0] r_wait_cnt;
    logic               r_timeout;
    logic               w_waiting;

    assign w_waiting      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ack;
    assign w_wait_expired = w_waiting &&
                            (r_wait_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, so each FETCH/MEM visit gets a
    // full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_next != r_state) r_wait_cnt <= '0;
            else if (w_waiting)    r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_wait_expired)    r_timeout  <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wait_expired = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule
`default_nettype wire
